// File: rtl/operand_seq_pkg.sv
// rtl/operand_seq_pkg.sv - shared types and constants for the operand sequencer
package operand_seq_pkg;

    localparam int OPW          = 4;
    localparam int TICK_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        GOT_X = 2'd1,
        GOT_Y = 2'd2,
        READY = 2'd3
    } seq_state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector for a load level
module rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic in,
    output logic rise
);

    logic r_in_q;

    // History starts at 1 so a level held high through reset is not seen as an edge
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_in_q <= 1'b1;
        end else begin
            r_in_q <= in;
        end
    end

    assign rise = in & ~r_in_q;

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - operand capture and mux-select sequencing for the 2-to-1 operand mux
module operand_sequencer
    import operand_seq_pkg::*;
#(
    parameter int TICK = TICK_DEFAULT,
    parameter int CW   = $clog2(TICK)
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [OPW-1:0] d,
    input  logic           ld_x,
    input  logic           ld_y,
    input  logic           auto,
    input  logic           sel_manual,
    output logic [OPW-1:0] X,
    output logic [OPW-1:0] Y,
    output logic           s,
    output logic           ready,
    output logic           tick
);

    localparam logic [CW-1:0] LP_CNT_LAST = CW'(TICK - 1);

    logic           w_rise_x;
    logic           w_rise_y;
    seq_state_t     r_state;
    seq_state_t     w_state_nxt;
    logic [OPW-1:0] r_x;
    logic [OPW-1:0] r_y;
    logic [CW-1:0]  r_cnt;
    logic           r_s;
    logic           r_tick;

    rise_detect u_rise_x (
        .Clock (Clock),
        .Reset (Reset),
        .in    (ld_x),
        .rise  (w_rise_x)
    );

    rise_detect u_rise_y (
        .Clock (Clock),
        .Reset (Reset),
        .in    (ld_y),
        .rise  (w_rise_y)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Track which operands have been loaded; READY holds until reset
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_rise_x && w_rise_y) begin
                    w_state_nxt = READY;
                end else if (w_rise_x) begin
                    w_state_nxt = GOT_X;
                end else if (w_rise_y) begin
                    w_state_nxt = GOT_Y;
                end
            end
            GOT_X: begin
                if (w_rise_y) begin
                    w_state_nxt = READY;
                end
            end
            GOT_Y: begin
                if (w_rise_x) begin
                    w_state_nxt = READY;
                end
            end
            READY:   w_state_nxt = READY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Operand capture on load-strobe rising edges, independent of state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (w_rise_x) begin
                r_x <= d;
            end
            if (w_rise_y) begin
                r_y <= d;
            end
        end
    end

    // Select generation: forced low until ready, manual follow, or auto alternation every TICK cycles
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_s    <= 1'b0;
            r_tick <= 1'b0;
        end else if (r_state != READY) begin
            r_cnt  <= '0;
            r_s    <= 1'b0;
            r_tick <= 1'b0;
        end else if (!auto) begin
            r_cnt  <= '0;
            r_s    <= sel_manual;
            r_tick <= 1'b0;
        end else if (r_cnt == LP_CNT_LAST) begin
            r_cnt  <= '0;
            r_s    <= ~r_s;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

    assign X     = r_x;
    assign Y     = r_y;
    assign s     = r_s;
    assign tick  = r_tick;
    assign ready = (r_state == READY);

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - directed self-checking bench for operand_sequencer
module tb_operand_sequencer;

    logic       Clock;
    logic       Reset;
    logic [3:0] d;
    logic       ld_x;
    logic       ld_y;
    logic       auto;
    logic       sel_manual;
    logic [3:0] X;
    logic [3:0] Y;
    logic       s;
    logic       ready;
    logic       tick;

    int n_total = 0;
    int n_bad   = 0;

    operand_sequencer #(.TICK(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .d          (d),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .auto       (auto),
        .sel_manual (sel_manual),
        .X          (X),
        .Y          (Y),
        .s          (s),
        .ready      (ready),
        .tick       (tick)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    logic s_m;
    logic t_m;

    initial begin
        Reset = 1'b1; d = 4'h0; ld_x = 1'b1; ld_y = 1'b0; auto = 1'b0; sel_manual = 1'b0;
        step(); step();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_val("rst_x", X, 4'h0);
        check_val("rst_y", Y, 4'h0);
        check_val("rst_s", s, 1'b0);
        check_val("rst_ready", ready, 1'b0);
        check_val("rst_tick", tick, 1'b0);

        ld_x = 1'b0; d = 4'hA; step();
        check_val("held_x", X, 4'h0);
        ld_x = 1'b1; step();
        check_val("load_x_a", X, 4'hA);
        check_val("gotx_ready", ready, 1'b0);
        check_val("gotx_s", s, 1'b0);

        ld_x = 1'b0; step();
        d = 4'h3; ld_x = 1'b1; step();
        check_val("reload_x_3", X, 4'h3);
        check_val("reload_ready", ready, 1'b0);

        ld_x = 1'b0; auto = 1'b0; sel_manual = 1'b1; d = 4'hC; ld_y = 1'b1; step();
        check_val("load_y_c", Y, 4'hC);
        check_val("pair_ready", ready, 1'b1);
        check_val("pair_s", s, 1'b0);
        ld_y = 1'b0; step();
        check_val("man_s1", s, 1'b1);
        sel_manual = 1'b0; step();
        check_val("man_s0", s, 1'b0);

        auto = 1'b1;
        s_m = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            step();
            t_m = (k % 4 == 0);
            if (t_m) s_m = ~s_m;
            check_val($sformatf("auto_s_k%0d", k), s, s_m);
            check_val($sformatf("auto_tick_k%0d", k), tick, t_m);
            if (k == 13) begin
                d = 4'hF; ld_x = 1'b1;
            end
            if (k == 14) begin
                check_val("reload_x_f", X, 4'hF);
                check_val("reload_ready_hold", ready, 1'b1);
                ld_x = 1'b0;
            end
        end

        auto = 1'b0; sel_manual = 1'b0; step();
        check_val("off_s0", s, 1'b0);
        check_val("off_tick", tick, 1'b0);
        sel_manual = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("off_s1_%0d", i), s, 1'b1);
            check_val($sformatf("off_tick_%0d", i), tick, 1'b0);
        end
        sel_manual = 1'b0; step();
        check_val("off_s_back0", s, 1'b0);

        auto = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_val($sformatf("reauto_s_k%0d", k), s, (k == 4) ? 1'b1 : 1'b0);
            check_val($sformatf("reauto_tick_k%0d", k), tick, (k == 4) ? 1'b1 : 1'b0);
        end
        step(); step();

        Reset = 1'b1; d = 4'h5; ld_x = 1'b1; step();
        check_val("mid_rst_x", X, 4'h0);
        check_val("mid_rst_y", Y, 4'h0);
        check_val("mid_rst_s", s, 1'b0);
        check_val("mid_rst_ready", ready, 1'b0);
        check_val("mid_rst_tick", tick, 1'b0);
        Reset = 1'b0; step();
        check_val("post_rst_x", X, 4'h0);
        ld_x = 1'b0; step();

        d = 4'h7; ld_x = 1'b1; ld_y = 1'b1; step();
        check_val("both_x", X, 4'h7);
        check_val("both_y", Y, 4'h7);
        check_val("both_ready", ready, 1'b1);
        check_val("both_s", s, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
